mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Single-port memory controller between the out-of-order core and the byte-wide RAM/IO bus.
- Arbitrates three requesters:
  - Instruction fetcher: 4-byte reads.
  - Load/store buffer (LSB): 1/2/4-byte loads, with sign/zero extension.
  - ROB: committed stores of 1/2/4 bytes.
- Serialises each access into per-byte RAM cycles and returns one done pulse per request.
- Sits directly downstream of the LSB, the fetcher and the ROB commit port.

Parameters:
- ADDR_W, 32, address width.
- IO_BASE, 32'h30000, first address of the IO region (used for IO write stall).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, all state holds
- in_rob_xbp  in  1  mispredict flush
- in_if_flag  in  1  fetch request (4 bytes)
- in_if_addr  in  32  fetch address
- out_if_flag  out  1  fetch done pulse
- out_if_inst  out  32  fetched word, little-endian
- in_lsb_flag  in  1  load request
- in_lsb_size  in  6  load size: 1, 2 or 4
- in_lsb_signed  in  1  1 = sign-extend
- in_lsb_addr  in  32  load address
- out_lsb_flag  out  1  load done pulse
- out_lsb_data  out  32  extended load data
- in_rob_flag  in  1  store request
- in_rob_size  in  6  store size: 1, 2 or 4
- in_rob_addr  in  32  store address
- in_rob_data  in  32  store data (low bytes used)
- out_rob_flag  out  1  store done pulse
- mem_din  in  8  RAM read byte, valid the cycle after its address was sampled
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address (registered)
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART transmit buffer full

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0.
- rdy low: no state change.
- States:
  - IDLE.
  - READ: tagged with source IF or LSB.
  - WRITE.
- Requests are levels. A requester holds its flag until it sees its done pulse; the controller latches the request at acceptance.
- Arbitration in IDLE, priority ROB store > LSB load > IF fetch.
- A request that is high in the same cycle as its own done pulse is not re-accepted in that cycle.
- READ of n bytes, acceptance at edge E0:
  - At edge E0+i (i = 0..n-1): mem_a <= A+i, mem_wr <= 0.
  - At edge E0+i+2: byte i is captured from mem_din.
  - At edge E0+n+1: done flag and data are registered; state returns to IDLE.
  - Latency: LW/fetch done is visible 5 cycles after acceptance; LB is visible 2 cycles after acceptance.
- Extension:
  - Size 1: sign extends from bit 7 if in_lsb_signed, else zero extends.
  - Size 2: same rule from bit 15.
  - Size 4: unchanged.
- WRITE of n bytes:
  - At edge E0+i (i = 0..n-1): mem_a <= A+i, mem_dout <= data[8i+7:8i], mem_wr <= 1.
  - At edge E0+n: mem_wr <= 0, out_rob_flag <= 1, state returns to IDLE.
- Done pulses last exactly one cycle.
- mem_wr is 0 whenever the controller is not in WRITE.
- Flush (in_rob_xbp high with rdy):
  - An in-flight READ (IF or LSB) is aborted; no done pulse is issued; state returns to IDLE; mem_wr = 0.
  - An in-flight WRITE continues to completion, because the store is already committed.
  - Requests present in the flush cycle are not accepted.
- Sizes other than 1/2/4 are treated as 4.
- Address arithmetic wraps modulo 2^32.

Optional Feature:
- Macro: MEM_IO_STALL_EN.
- When defined: before each write byte whose address is >= IO_BASE, the controller waits while io_buffer_full = 1. During the wait, mem_wr = 0 and the byte counter is frozen; the byte is driven in the first cycle io_buffer_full is 0.
- When undefined: io_buffer_full is ignored and writes proceed every cycle.

Decomposition:
- Shared definitions package:
  - Widths: DATA_TYPE, ADDR_TYPE.
  - TRUE/FALSE, ZERO_WORD.
  - RAM_IO_PORT (32'h30000).
  - State encodings: IDLE/READ/WRITE.
  - Source encodings: SRC_IF/SRC_LSB/SRC_ROB.
- One sub-module is natural: mem_ext. It is combinational and performs load sign/zero extension from size, signed flag and the 32-bit raw value. It is reusable by the LSB IO path.

Test Plan:
- LW from 0x100 holding bytes 0x78,0x56,0x34,0x12 -> out_lsb_flag pulses 5 cycles after acceptance with out_lsb_data = 0x12345678; mem_a sequence 0x100..0x103.
- LB signed of byte 0x80, then LBU of the same byte -> 0xFFFFFF80, then 0x00000080.
- SH 0xBEEF to 0x200 -> mem_wr = 1 for 2 cycles; (0x200, 0xEF) then (0x201, 0xBE); out_rob_flag 2 cycles after acceptance.
- IF, LSB and ROB raised in the same cycle -> service order store, then load, then fetch; exactly one done pulse each.
- Flush 2 cycles into a fetch -> no out_if_flag; IDLE next cycle. Flush during SW -> all 4 bytes written and out_rob_flag still pulses.
- With MEM_IO_STALL_EN: SB to 0x30000 while io_buffer_full = 1 for 3 cycles -> mem_wr stays 0 for those cycles, then 1 cycle write. Without the macro -> immediate write.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, constants and encodings for the memory controller
package mem_ctrl_pkg;
  typedef logic [31:0] DATA_TYPE;
  typedef logic [31:0] ADDR_TYPE;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam DATA_TYPE ZERO_WORD = 32'h0;
  localparam ADDR_TYPE RAM_IO_PORT = 32'h30000;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] SRC_IF = 2'd0;
  localparam logic [1:0] SRC_LSB = 2'd1;
  localparam logic [1:0] SRC_ROB = 2'd2;
  function automatic logic [2:0] norm_size(input logic [5:0] s);
    return (s == 6'd1) ? 3'd1 : (s == 6'd2) ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl_ext.sv
// mem_ext: sign/zero extension of a 1/2/4-byte load value
module mem_ext
  import mem_ctrl_pkg::*;
(
  input  logic [2:0] size,
  input  logic       sgn,
  input  DATA_TYPE   raw,
  output DATA_TYPE   data
);
  always_comb
    data = (size == 3'd1) ? {{24{sgn & raw[7]}}, raw[7:0]} :
           (size == 3'd2) ? {{16{sgn & raw[15]}}, raw[15:0]} : raw;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO controller for fetch, load and store; MEM_IO_STALL_EN enables IO write stall
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = RAM_IO_PORT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_rob_xbp,
  input  logic              in_if_flag,
  input  logic [ADDR_W-1:0] in_if_addr,
  output logic              out_if_flag,
  output DATA_TYPE          out_if_inst,
  input  logic              in_lsb_flag,
  input  logic [5:0]        in_lsb_size,
  input  logic              in_lsb_signed,
  input  logic [ADDR_W-1:0] in_lsb_addr,
  output logic              out_lsb_flag,
  output DATA_TYPE          out_lsb_data,
  input  logic              in_rob_flag,
  input  logic [5:0]        in_rob_size,
  input  logic [ADDR_W-1:0] in_rob_addr,
  input  DATA_TYPE          in_rob_data,
  output logic              out_rob_flag,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
`ifdef MEM_IO_STALL_EN
  localparam logic IO_STALL = TRUE;
`else
  localparam logic IO_STALL = FALSE;
`endif
  logic [1:0] state, src;
  logic [2:0] c, n, widx, cap;
  logic sgn, req_if, req_lsb, req_rob, stall;
  logic [ADDR_W-1:0] addr, wbase, waddr;
  DATA_TYPE wdat, buf_q, wsrc, raw, ext_data;
  logic [7:0] wbyte;
  always_comb begin
    req_rob = in_rob_flag & ~out_rob_flag;
    req_lsb = in_lsb_flag & ~out_lsb_flag;
    req_if = in_if_flag & ~out_if_flag;
    widx = (state == IDLE) ? 3'd0 : c;
    wbase = (state == IDLE) ? in_rob_addr : addr;
    wsrc = (state == IDLE) ? in_rob_data : wdat;
    waddr = wbase + {{(ADDR_W-3){1'b0}}, widx};
    wbyte = wsrc[{widx[1:0], 3'b000} +: 8];
    stall = IO_STALL & (waddr >= IO_BASE) & io_buffer_full;
    cap = c - 3'd2;
    raw = buf_q | (DATA_TYPE'(mem_din) << {cap[1:0], 3'b000});
  end
  mem_ext u_ext (.size(n), .sgn(sgn), .raw(raw), .data(ext_data));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      src <= SRC_IF;
      c <= 3'd0;
      n <= 3'd0;
      sgn <= FALSE;
      addr <= '0;
      wdat <= ZERO_WORD;
      buf_q <= ZERO_WORD;
      out_if_flag <= FALSE;
      out_if_inst <= ZERO_WORD;
      out_lsb_flag <= FALSE;
      out_lsb_data <= ZERO_WORD;
      out_rob_flag <= FALSE;
      mem_dout <= 8'h0;
      mem_a <= '0;
      mem_wr <= FALSE;
    end else if (rdy) begin
      out_if_flag <= FALSE;
      out_lsb_flag <= FALSE;
      out_rob_flag <= FALSE;
      case (state)
        IDLE: if (!in_rob_xbp) begin
          if (req_rob) begin
            state <= WRITE;
            src <= SRC_ROB;
            addr <= in_rob_addr;
            wdat <= in_rob_data;
            n <= norm_size(in_rob_size);
            mem_a <= waddr;
            mem_dout <= wbyte;
            mem_wr <= !stall;
            c <= stall ? 3'd0 : 3'd1;
          end else if (req_lsb || req_if) begin
            state <= READ;
            src <= req_lsb ? SRC_LSB : SRC_IF;
            addr <= req_lsb ? in_lsb_addr : in_if_addr;
            mem_a <= req_lsb ? in_lsb_addr : in_if_addr;
            n <= req_lsb ? norm_size(in_lsb_size) : 3'd4;
            sgn <= req_lsb & in_lsb_signed;
            buf_q <= ZERO_WORD;
            mem_wr <= FALSE;
            c <= 3'd1;
          end
        end
        READ: if (in_rob_xbp) begin
          state <= IDLE;
          mem_wr <= FALSE;
        end else begin
          if (c < n) mem_a <= addr + {{(ADDR_W-3){1'b0}}, c};
          if (c >= 3'd2) buf_q <= raw;
          if (c == n + 3'd1) begin
            state <= IDLE;
            out_if_flag <= (src == SRC_IF);
            out_lsb_flag <= (src == SRC_LSB);
            if (src == SRC_IF) out_if_inst <= raw;
            else out_lsb_data <= ext_data;
          end
          c <= c + 3'd1;
        end
        WRITE: if (c == n) begin
          state <= IDLE;
          mem_wr <= FALSE;
          out_rob_flag <= TRUE;
        end else if (stall) begin
          mem_wr <= FALSE;
        end else begin
          mem_a <= waddr;
          mem_dout <= wbyte;
          mem_wr <= TRUE;
          c <= c + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a byte-wide RAM model
module tb_mem_ctrl;
  logic clk = 0, rst = 1, rdy = 1, in_rob_xbp = 0;
  logic in_if_flag = 0, in_lsb_flag = 0, in_lsb_signed = 0, in_rob_flag = 0;
  logic [31:0] in_if_addr = 0, in_lsb_addr = 0, in_rob_addr = 0, in_rob_data = 0;
  logic [5:0] in_lsb_size = 0, in_rob_size = 0;
  logic out_if_flag, out_lsb_flag, out_rob_flag, mem_wr;
  logic io_buffer_full = 0;
  logic [31:0] out_if_inst, out_lsb_data, mem_a;
  logic [7:0] mem_din = 0, mem_dout;
  logic [7:0] ram [0:1023];
  int checks = 0, errors = 0, n_if = 0, n_lsb = 0, n_rob = 0;
  typedef struct {int kind; logic [31:0] d;} ev_t;
  typedef struct {logic [31:0] a; logic [7:0] d;} wr_t;
  ev_t sbq[$];
  wr_t wq[$];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .in_rob_xbp(in_rob_xbp),
    .in_if_flag(in_if_flag), .in_if_addr(in_if_addr), .out_if_flag(out_if_flag), .out_if_inst(out_if_inst),
    .in_lsb_flag(in_lsb_flag), .in_lsb_size(in_lsb_size), .in_lsb_signed(in_lsb_signed),
    .in_lsb_addr(in_lsb_addr), .out_lsb_flag(out_lsb_flag), .out_lsb_data(out_lsb_data),
    .in_rob_flag(in_rob_flag), .in_rob_size(in_rob_size), .in_rob_addr(in_rob_addr),
    .in_rob_data(in_rob_data), .out_rob_flag(out_rob_flag),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rdy) mem_din <= ram[mem_a[9:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_ev(input int kind, input logic [31:0] d);
    ev_t e;
    if (sbq.size() == 0) chk("unexpected_done", 32'(kind), 32'hFFFF_FFFF);
    else begin
      e = sbq.pop_front();
      chk("done_order", 32'(kind), 32'(e.kind));
      if (kind != 2) chk(kind == 0 ? "if_inst" : "lsb_data", d, e.d);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    wr_t w;
    if (out_if_flag) begin n_if++; pop_ev(0, out_if_inst); end
    if (out_lsb_flag) begin n_lsb++; pop_ev(1, out_lsb_data); end
    if (out_rob_flag) begin n_rob++; pop_ev(2, 32'h0); end
    if (mem_wr) begin
      if (wq.size() == 0) chk("unexpected_write", mem_a, 32'hFFFF_FFFF);
      else begin
        w = wq.pop_front();
        chk("wr_addr", mem_a, w.a);
        chk("wr_data", {24'h0, mem_dout}, {24'h0, w.d});
      end
    end
  end

  task automatic do_req(input int kind, input logic [31:0] a, input logic [5:0] sz, input logic sg,
                        input logic [31:0] d, input int lat, input int gap, input int full_cyc, input int xk);
    int k, n;
    logic done;
    n = (sz == 6'd1) ? 1 : (sz == 6'd2) ? 2 : 4;
    if (kind == 2) begin
      for (int i = 0; i < n; i++) wq.push_back('{a: a + 32'(i), d: d[8*i +: 8]});
      sbq.push_back('{kind: 2, d: 32'h0});
      in_rob_flag = 1; in_rob_addr = a; in_rob_size = sz; in_rob_data = d;
    end else begin
      sbq.push_back('{kind: kind, d: d});
      if (kind == 0) begin in_if_flag = 1; in_if_addr = a; end
      else begin in_lsb_flag = 1; in_lsb_addr = a; in_lsb_size = sz; in_lsb_signed = sg; end
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (gap > 0 && k == 2) rdy = 0;
      if (gap > 0 && k == 2 + gap) rdy = 1;
      if (k == full_cyc) io_buffer_full = 0;
      if (k == xk) in_rob_xbp = 1;
      if (k == xk + 1) in_rob_xbp = 0;
      if (kind != 2 && gap == 0 && k <= n) chk("rd_addr", mem_a, a + 32'(k - 1));
      done = (kind == 0) ? out_if_flag : (kind == 1) ? out_lsb_flag : out_rob_flag;
    end while (!done && k < 40);
    chk("done_seen", {31'h0, done}, 32'h1);
    chk("latency", 32'(k - 1), 32'(lat));
    in_if_flag = 0; in_lsb_flag = 0; in_rob_flag = 0; in_rob_xbp = 0; io_buffer_full = 0;
    @(negedge clk);
  endtask

  initial begin
    int b_if, b_lsb, b_rob, k;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h78; ram[10'h101] = 8'h56; ram[10'h102] = 8'h34; ram[10'h103] = 8'h12;
    ram[10'h110] = 8'h80;
    ram[10'h120] = 8'h34; ram[10'h121] = 8'hF2;
    repeat (2) @(negedge clk);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_flags", {29'h0, out_if_flag, out_lsb_flag, out_rob_flag}, 32'h0);
    chk("rst_lsb_data", out_lsb_data, 32'h0);
    chk("rst_if_inst", out_if_inst, 32'h0);
    rst = 0;
    @(negedge clk);
    do_req(1, 32'h100, 6'd4, 0, 32'h12345678, 5, 0, 0, 0);
    do_req(1, 32'h110, 6'd1, 1, 32'hFFFFFF80, 2, 0, 0, 0);
    do_req(1, 32'h110, 6'd1, 0, 32'h00000080, 2, 0, 0, 0);
    do_req(1, 32'h120, 6'd2, 1, 32'hFFFFF234, 3, 0, 0, 0);
    do_req(1, 32'h120, 6'd2, 0, 32'h0000F234, 3, 0, 0, 0);
    do_req(1, 32'h100, 6'd3, 0, 32'h12345678, 5, 0, 0, 0);
    do_req(1, 32'h100, 6'd4, 1, 32'h12345678, 8, 3, 0, 0);
    do_req(0, 32'h100, 6'd4, 0, 32'h12345678, 5, 0, 0, 0);
    do_req(2, 32'h200, 6'd2, 0, 32'h0000BEEF, 2, 0, 0, 0);
    do_req(2, 32'h300, 6'd4, 0, 32'hDEADBEEF, 4, 0, 0, 0);
    do_req(2, 32'hFFFFFFFF, 6'd2, 0, 32'h0000A55A, 2, 0, 0, 0);
    io_buffer_full = 1;
`ifdef MEM_IO_STALL_EN
    do_req(2, 32'h30000, 6'd1, 0, 32'h00000041, 4, 0, 3, 0);
`else
    do_req(2, 32'h30000, 6'd1, 0, 32'h00000041, 1, 0, 3, 0);
`endif
    // store, load and fetch raised together must be served ROB, LSB, IF
    b_if = n_if; b_lsb = n_lsb; b_rob = n_rob;
    wq.push_back('{a: 32'h204, d: 8'h5A});
    sbq.push_back('{kind: 2, d: 32'h0});
    sbq.push_back('{kind: 1, d: 32'h12345678});
    sbq.push_back('{kind: 0, d: 32'h00000080});
    in_rob_flag = 1; in_rob_addr = 32'h204; in_rob_size = 6'd1; in_rob_data = 32'h5A;
    in_lsb_flag = 1; in_lsb_addr = 32'h100; in_lsb_size = 6'd4; in_lsb_signed = 0;
    in_if_flag = 1; in_if_addr = 32'h110;
    k = 0;
    while ((in_rob_flag || in_lsb_flag || in_if_flag) && k < 60) begin
      @(negedge clk);
      k++;
      if (out_rob_flag) in_rob_flag = 0;
      if (out_lsb_flag) in_lsb_flag = 0;
      if (out_if_flag) in_if_flag = 0;
    end
    repeat (8) @(negedge clk);
    chk("arb_rob_pulses", 32'(n_rob - b_rob), 32'd1);
    chk("arb_lsb_pulses", 32'(n_lsb - b_lsb), 32'd1);
    chk("arb_if_pulses", 32'(n_if - b_if), 32'd1);
    // flush two cycles into a fetch
    b_if = n_if;
    in_if_flag = 1; in_if_addr = 32'h100;
    repeat (2) @(negedge clk);
    in_rob_xbp = 1; in_if_flag = 0;
    @(negedge clk);
    in_rob_xbp = 0;
    chk("flush_mem_wr", {31'h0, mem_wr}, 32'h0);
    repeat (10) @(negedge clk);
    chk("flush_no_if_done", 32'(n_if - b_if), 32'd0);
    do_req(1, 32'h110, 6'd1, 1, 32'hFFFFFF80, 2, 0, 0, 0);
    do_req(2, 32'h310, 6'd4, 0, 32'hCAFEF00D, 4, 0, 0, 1);
    // a request seen in the flush cycle must not be accepted
    b_lsb = n_lsb;
    in_rob_xbp = 1; in_lsb_flag = 1; in_lsb_addr = 32'h110; in_lsb_size = 6'd1;
    @(negedge clk);
    in_rob_xbp = 0; in_lsb_flag = 0;
    repeat (8) @(negedge clk);
    chk("flush_idle_no_accept", 32'(n_lsb - b_lsb), 32'd0);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
